// File: rtl/pwm_multi_burst.sv
// Multi-channel PWM with a shared period counter, burst/single-shot modes and shadowed configuration.
// Optional: define PWM_CENTER_ALIGN_EN for up/down (center-aligned) counting.
module pwm_multi_burst #(
    parameter int unsigned CH = 4,
    parameter int unsigned CW = 16,
    parameter int unsigned BW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CW-1:0]    period,
    input  logic [CH*CW-1:0] duty,
    input  logic [BW-1:0]    burst_len,
    input  logic [BW-1:0]    gap_len,
    input  logic             upd,
    output logic [CH-1:0]    pwm_out,
    output logic             period_tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] M_CONT   = 2'd0;
    localparam logic [1:0] M_SINGLE = 2'd2;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          pcnt_q, pcnt_d;
    logic                   upd_pend_q, upd_pend_d;
    logic                   lock_q, lock_d;
    logic [CW-1:0]          p_s_q, p_s_d;
    logic [CH-1:0][CW-1:0]  d_s_q, d_s_d;
    logic [1:0]             mode_s_q, mode_s_d;
    logic [BW-1:0]          bl_s_q, bl_s_d;
    logic [BW-1:0]          gl_s_q, gl_s_d;
    logic [CH-1:0]          pwm_out_q, pwm_out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   boundary_c;
    logic [CW-1:0]          cnt_adv_c;
    logic [1:0]             mode_norm_c;
    logic [BW-1:0]          pcnt_inc_c;
    logic [BW-1:0]          bl_eff_c;
    logic                   reload_c;

`ifdef PWM_CENTER_ALIGN_EN
    logic                   dir_q, dir_d;
    logic                   dir_adv_c;
    logic [CW-1:0]          p_eff_c;
`endif

    assign mode_norm_c = (mode == 2'd3) ? M_CONT : mode;
    assign pcnt_inc_c  = pcnt_q + BW'(1);
    assign bl_eff_c    = (bl_s_q == '0) ? BW'(1) : bl_s_q;
    assign reload_c    = boundary_c && (upd_pend_q || upd);
    assign period_tick = boundary_c;

    // Period counter: next count value and boundary detection
`ifdef PWM_CENTER_ALIGN_EN
    always_comb begin
        p_eff_c    = (p_s_q == '0) ? CW'(1) : p_s_q;
        cnt_adv_c  = cnt_q + CW'(1);
        dir_adv_c  = dir_q;
        boundary_c = 1'b0;
        if (!dir_q) begin
            if (cnt_q >= p_eff_c) begin
                if (p_eff_c == CW'(1)) begin
                    cnt_adv_c  = '0;
                    boundary_c = (state_q != S_IDLE);
                end else begin
                    cnt_adv_c = cnt_q - CW'(1);
                    dir_adv_c = 1'b1;
                end
            end
        end else if (cnt_q <= CW'(1)) begin
            cnt_adv_c  = '0;
            dir_adv_c  = 1'b0;
            boundary_c = (state_q != S_IDLE);
        end else begin
            cnt_adv_c = cnt_q - CW'(1);
        end
    end
`else
    always_comb begin
        boundary_c = (state_q != S_IDLE) && (cnt_q == p_s_q);
        cnt_adv_c  = (cnt_q == p_s_q) ? '0 : cnt_q + CW'(1);
    end
`endif

    // Next-state, shadow and output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pcnt_d     = pcnt_q;
        upd_pend_d = upd_pend_q;
        lock_d     = lock_q;
        p_s_d      = p_s_q;
        d_s_d      = d_s_q;
        mode_s_d   = mode_s_q;
        bl_s_d     = bl_s_q;
        gl_s_d     = gl_s_q;
        done_d     = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d      = dir_q;
`endif

        case (state_q)
            S_IDLE: begin
                upd_pend_d = 1'b0;
                cnt_d      = '0;
                pcnt_d     = '0;
                if (!en) begin
                    lock_d = 1'b0;
                end
                // A finished single burst stays idle until en has been seen low
                if (en && !lock_q) begin
                    state_d  = S_RUN;
                    p_s_d    = period;
                    d_s_d    = duty;
                    mode_s_d = mode_norm_c;
                    bl_s_d   = burst_len;
                    gl_s_d   = gap_len;
`ifdef PWM_CENTER_ALIGN_EN
                    dir_d    = 1'b0;
`endif
                end
            end
            S_RUN, S_GAP: begin
                cnt_d      = cnt_adv_c;
                upd_pend_d = upd_pend_q | upd;
`ifdef PWM_CENTER_ALIGN_EN
                dir_d      = dir_adv_c;
`endif
                if (boundary_c) begin
                    pcnt_d = pcnt_inc_c;
                    if (state_q == S_RUN) begin
                        if ((mode_s_q != M_CONT) && (pcnt_inc_c >= bl_eff_c)) begin
                            pcnt_d = '0;
                            if (mode_s_q == M_SINGLE) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                                lock_d  = en;
                            end else if (gl_s_q != '0) begin
                                state_d = S_GAP;
                            end
                        end
                    end else if (pcnt_inc_c >= gl_s_q) begin
                        state_d = S_RUN;
                        pcnt_d  = '0;
                    end

                    if (!en) begin
                        state_d = S_IDLE;
                    end

                    if (state_d == S_IDLE) begin
                        cnt_d      = '0;
                        pcnt_d     = '0;
                        upd_pend_d = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
                        dir_d      = 1'b0;
`endif
                    end else if (reload_c) begin
                        p_s_d      = period;
                        d_s_d      = duty;
                        mode_s_d   = mode_norm_c;
                        bl_s_d     = burst_len;
                        gl_s_d     = gap_len;
                        upd_pend_d = 1'b0;
                        if (mode_norm_c != mode_s_q) begin
                            pcnt_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pcnt_d  = '0;
            end
        endcase

        for (int i = 0; i < int'(CH); i++) begin
            pwm_out_d[i] = (state_q == S_RUN) && (cnt_q < d_s_q[i]);
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pcnt_q     <= '0;
            upd_pend_q <= 1'b0;
            lock_q     <= 1'b0;
            p_s_q      <= '0;
            d_s_q      <= '0;
            mode_s_q   <= M_CONT;
            bl_s_q     <= '0;
            gl_s_q     <= '0;
            pwm_out_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pcnt_q     <= pcnt_d;
            upd_pend_q <= upd_pend_d;
            lock_q     <= lock_d;
            p_s_q      <= p_s_d;
            d_s_q      <= d_s_d;
            mode_s_q   <= mode_s_d;
            bl_s_q     <= bl_s_d;
            gl_s_q     <= gl_s_d;
            pwm_out_q  <= pwm_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q      <= dir_d;
`endif
        end
    end

    assign pwm_out = pwm_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pwm_multi_burst.sv
// Bench for pwm_multi_burst (edge-aligned build): vector table, random runs against a timeline model,
// and hand sequences for shadow reload and mid-period reset.
module tb_pwm_multi_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] period;
    logic [63:0] duty;
    logic [7:0]  burst_len;
    logic [7:0]  gap_len;
    logic        upd;
    logic [3:0]  pwm_out;
    logic        period_tick;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    pwm_multi_burst #(.CH(4), .CW(16), .BW(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .period(period), .duty(duty),
        .burst_len(burst_len), .gap_len(gap_len), .upd(upd), .pwm_out(pwm_out),
        .period_tick(period_tick), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int p;
        int d0, d1, d2, d3;
        int mode, bl, gl, l;
        int hi0, hi1, hi2, hi3;
        int busy_n, done_n, tick_n;
    } vec_t;

    // Expected activity timeline: one entry per busy cycle (1 = RUN, 2 = GAP) with tick-in-period
    int tl_kind[$];
    int tl_t[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_period(input int kind, input int p);
        for (int t = 0; t <= p; t++) begin
            tl_kind.push_back(kind);
            tl_t.push_back(t);
        end
    endfunction

    // Lay out whole periods until the run ends: single burst complete, or en low at a period end
    task automatic build_tl(input int p, input int md, input int bl, input int gl, input int l,
                            output bit with_done);
        int m;
        int nb;
        bit stop;
        tl_kind.delete();
        tl_t.delete();
        with_done = 1'b0;
        stop = 1'b0;
        m  = (md == 3) ? 0 : md;
        nb = (m == 0) ? 1 : ((bl == 0) ? 1 : bl);
        while (!stop) begin
            for (int k = 0; k < nb && !stop; k++) begin
                push_period(1, p);
                if (m == 2 && k == nb - 1) begin
                    stop = 1'b1;
                    with_done = 1'b1;
                end else if (tl_kind.size() - 1 >= l) begin
                    stop = 1'b1;
                end
            end
            if (m == 1) begin
                for (int k = 0; k < gl && !stop; k++) begin
                    push_period(2, p);
                    if (tl_kind.size() - 1 >= l) stop = 1'b1;
                end
            end
            if (tl_kind.size() > 3000) stop = 1'b1;
        end
    endtask

    task automatic run_cfg(input int p, input logic [3:0][15:0] dv, input int md, input int bl,
                           input int gl, input int l, input string tag,
                           output int hi[4], output int busy_n, output int done_n, output int tick_n);
        bit wd;
        int len;
        int total;
        int exp_pwm;
        build_tl(p, md, bl, gl, l, wd);
        len = tl_kind.size();
        total = ((l > len) ? l : len) + 4;
        for (int i = 0; i < 4; i++) hi[i] = 0;
        busy_n = 0; done_n = 0; tick_n = 0;
        en = 1'b0; upd = 1'b0;
        step(); step();
        period = 16'(p); duty = dv; mode = 2'(md);
        burst_len = 8'(bl); gap_len = 8'(gl); en = 1'b1;
        chk({tag, " pre_busy"}, int'(busy), 0);
        step();
        for (int c = 0; c < total; c++) begin
            en = (c < l);
            for (int i = 0; i < 4; i++) begin
                exp_pwm = (c >= 1 && c - 1 < len && tl_kind[c-1] == 1 && tl_t[c-1] < int'(dv[i])) ? 1 : 0;
                chk($sformatf("%s pwm%0d c%0d", tag, i, c), int'(pwm_out[i]), exp_pwm);
                hi[i] += int'(pwm_out[i]);
            end
            chk($sformatf("%s busy c%0d", tag, c), int'(busy), (c < len) ? 1 : 0);
            chk($sformatf("%s tick c%0d", tag, c), int'(period_tick), (c < len && tl_t[c] == p) ? 1 : 0);
            chk($sformatf("%s done c%0d", tag, c), int'(done), (wd && c == len) ? 1 : 0);
            busy_n += int'(busy);
            done_n += int'(done);
            tick_n += int'(period_tick);
            step();
        end
        en = 1'b0;
    endtask

    vec_t vecs[6];
    int hi[4];
    int busy_n, done_n, tick_n;
    int sum;
    logic [3:0][15:0] dv;

    initial begin
        //            p  d0 d1 d2 d3 md bl gl  l  hi0 hi1 hi2 hi3 busy done tick
        vecs[0] = '{9, 0, 3, 9, 12, 0, 0, 0, 25, 0, 9, 27, 30, 30, 0, 3};
        vecs[1] = '{4, 2, 0, 5, 1,  1, 3, 2, 40, 12, 0, 30, 6, 45, 0, 9};
        vecs[2] = '{4, 2, 4, 0, 7,  2, 2, 3, 30, 4, 8, 0, 10, 10, 1, 2};
        vecs[3] = '{0, 0, 1, 1, 2,  3, 0, 0, 5,  0, 6, 6, 6, 6, 0, 6};
        vecs[4] = '{2, 1, 2, 3, 0,  1, 0, 0, 7,  3, 6, 9, 0, 9, 0, 3};
        vecs[5] = '{3, 1, 1, 1, 1,  2, 3, 0, 6,  2, 2, 2, 2, 8, 0, 2};

        rst = 1'b1; en = 1'b0; mode = '0; period = '0; duty = '0;
        burst_len = '0; gap_len = '0; upd = 1'b0;
        step(); step();
        chk("reset pwm", int'(pwm_out), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset tick", int'(period_tick), 0);
        chk("reset done", int'(done), 0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 6; v++) begin
            dv = {16'(vecs[v].d3), 16'(vecs[v].d2), 16'(vecs[v].d1), 16'(vecs[v].d0)};
            run_cfg(vecs[v].p, dv, vecs[v].mode, vecs[v].bl, vecs[v].gl, vecs[v].l,
                    $sformatf("vec%0d", v), hi, busy_n, done_n, tick_n);
            chk($sformatf("vec%0d hi0", v), hi[0], vecs[v].hi0);
            chk($sformatf("vec%0d hi1", v), hi[1], vecs[v].hi1);
            chk($sformatf("vec%0d hi2", v), hi[2], vecs[v].hi2);
            chk($sformatf("vec%0d hi3", v), hi[3], vecs[v].hi3);
            chk($sformatf("vec%0d busy_n", v), busy_n, vecs[v].busy_n);
            chk($sformatf("vec%0d done_n", v), done_n, vecs[v].done_n);
            chk($sformatf("vec%0d tick_n", v), tick_n, vecs[v].tick_n);
        end

        for (int r = 0; r < 16; r++) begin
            int p;
            p = int'($urandom_range(0, 6));
            for (int i = 0; i < 4; i++) dv[i] = 16'($urandom_range(0, p + 2));
            run_cfg(p, dv, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), int'($urandom_range(1, 40)),
                    $sformatf("rnd%0d", r), hi, busy_n, done_n, tick_n);
        end

        // Shadow reload: mid-period upd, upd on the boundary cycle, input change without upd
        en = 1'b0; upd = 1'b0;
        step(); step();
        period = 16'd9; mode = 2'd0; duty = 64'd5; en = 1'b1;
        step();
        sum = 0;
        for (int c = 0; c <= 60; c++) begin
            upd = 1'b0;
            if (c == 2)  begin duty = 64'd8; upd = 1'b1; end
            if (c == 19) begin duty = 64'd3; upd = 1'b1; end
            if (c == 22) duty = 64'd1;
            if (c == 41) en = 1'b0;
            if (c >= 1 && c <= 40) sum += int'(pwm_out[0]);
            if (c == 10) begin chk("upd period1 hi", sum, 5); sum = 0; end
            if (c == 20) begin chk("upd period2 hi", sum, 8); sum = 0; end
            if (c == 30) begin chk("upd boundary hi", sum, 3); sum = 0; end
            if (c == 40) begin chk("no_upd hold hi", sum, 3); sum = 0; end
            if (c == 9)  chk("upd tick c9", int'(period_tick), 1);
            if (c == 49) chk("upd busy before stop", int'(busy), 1);
            if (c == 50) chk("upd busy after stop", int'(busy), 0);
            step();
        end
        upd = 1'b0;

        // Synchronous reset in the middle of a period, then restart with en held high
        period = 16'd9; mode = 2'd0; duty = 64'd5; en = 1'b1;
        step();
        for (int c = 0; c <= 8; c++) begin
            rst = (c == 4);
            if (c == 3) chk("rst pre pwm0", int'(pwm_out[0]), 1);
            if (c == 5) begin
                chk("rst pwm", int'(pwm_out), 0);
                chk("rst busy", int'(busy), 0);
                chk("rst tick", int'(period_tick), 0);
                chk("rst done", int'(done), 0);
            end
            if (c == 6) begin
                chk("rst restart busy", int'(busy), 1);
                chk("rst restart pwm", int'(pwm_out[0]), 0);
            end
            if (c == 7) chk("rst restart pwm0", int'(pwm_out[0]), 1);
            step();
        end
        rst = 1'b0; en = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
